span_cme_loader: RTL
====================

Name: span_cme_loader

Overview:
- Bus initiator that drives the span_cme register-slave interface (offset/writeData/write/chipselect/read/readData).
- Accepts a stream of 16-bit risk-parameter words, writes them to consecutive offsets 0..NUM_REGS-1, waits a fixed compute interval, reads the result register and returns it on a valid/ready port.
- Replaces hand-sequenced bench writes; sits between the host-side parameter source and span_cme.

Parameters:
- NUM_REGS, 34, number of parameter words per load (offsets 0..NUM_REGS-1); range 1..63.
- RESULT_OFFSET, 34, offset read to fetch the computed result.
- WAIT_CYCLES, 8, idle cycles between the last write and the result read (range 0..255).
- READ_LATENCY, 1, cycles from the av_read assertion cycle to valid av_readData (range 1..3).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load sequence when idle.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- in_data  in  16  parameter word (two's complement where signed).
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- offset  out  6  register offset to span_cme.
- writeData  out  16  write data to span_cme.
- write  out  1  write strobe.
- read  out  1  read strobe.
- chipselect  out  1  asserted with write or read.
- readData  in  16  read data from span_cme.
- result_data  out  16  captured result.
- result_valid  out  1  result_data valid.
- result_ready  in  1  consumer accepts the result.
- check_err  out  1  readback checksum mismatch; constant 0 when LOADER_READBACK_EN is not defined.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including offset, writeData, result_data and check_err.
  - Word count and wait counter clear.
  - Reset mid-sequence abandons the sequence with no further bus activity.
- State flow: IDLE -> LOAD -> [VERIFY] -> WAIT -> READ -> CAPTURE -> HOLD -> IDLE.
- IDLE:
  - in_ready=0.
  - start=1 moves to LOAD, clears the word count, clears check_err, and sets busy next cycle.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready = (count < NUM_REGS).
  - On an in_valid&&in_ready cycle, the next cycle registers write=1, chipselect=1, offset=count, writeData=in_data, then count increments. Write latency is 1 cycle.
  - One write per accepted word; back-to-back accepts produce back-to-back writes.
  - A cycle with no accept drives write=0 and chipselect=0; offset and writeData hold their last values.
  - After the write to offset NUM_REGS-1 is issued, go to VERIFY (feature enabled) or WAIT.
  - Words arriving while in_ready=0 are not consumed.
- WAIT:
  - All strobes are 0.
  - Counts WAIT_CYCLES cycles, then goes to READ.
  - With WAIT_CYCLES=0, READ follows immediately.
- READ:
  - One cycle with read=1, chipselect=1, offset=RESULT_OFFSET, write=0.
  - Then go to CAPTURE.
- CAPTURE:
  - Samples readData READ_LATENCY cycles after the read cycle into result_data.
  - Then go to HOLD with result_valid=1.
- HOLD:
  - result_data is held stable while result_valid=1.
  - Leave on result_valid&&result_ready, going to IDLE. busy and result_valid clear in that same transition.
- write and read are never asserted in the same cycle; chipselect = write|read at all times.
- Arithmetic: the offset counter is 6-bit with no wrap, since NUM_REGS ≤ 63. Data passes through bit-exact with no sign handling.

Optional Feature:
- Macro: LOADER_READBACK_EN.
- Defined:
  - LOAD XOR-accumulates every written word into a 16-bit checksum.
  - VERIFY reads offsets 0..NUM_REGS-1 sequentially (one read per READ_LATENCY+1 cycles) and XOR-accumulates the readData values.
  - At the end of VERIFY, check_err=1 if the two checksums differ. The sequence still continues to WAIT.
  - check_err holds until the next accepted start or reset.
- Not defined: the VERIFY state and checksum logic are absent, LOAD goes directly to WAIT, and check_err is tied to 0.

Test Plan:
- Reset mid-LOAD (assert reset after the 5th write):
  - All outputs 0 immediately.
  - No further write or read.
  - A new start produces a fresh sequence beginning at offset 0.
- Nominal load:
  - Stimulus: start, then stream 96,15,0xFFFB,10,0xFFF1,5,... (34 words) with in_valid always 1.
  - Response: 34 consecutive write cycles, offsets 0..33, writeData matching the input; read at offset 34 exactly WAIT_CYCLES+1 cycles after the last write; result_data = model value; result_valid=1.
- Input bubbles:
  - Stimulus: in_valid toggled 1/0 each cycle.
  - Response: writes occur only in cycles after accepts, offsets stay contiguous, total 34 writes.
- Result backpressure:
  - Stimulus: result_ready=0 for 10 cycles, then 1.
  - Response: result_valid and result_data stable for all 10 cycles; return to IDLE the cycle after the handshake; busy=0.
- Start while busy:
  - Stimulus: pulse start during LOAD and during WAIT.
  - Response: no restart; offset sequence unaffected.
- LOADER_READBACK_EN checksum:
  - Stimulus: slave model corrupts offset 7 on readback.
  - Response: check_err=1 after VERIFY, result still returned.
  - With a clean slave model: check_err=0.

Source files
------------

// File: rtl/span_cme_loader.sv
// span_cme_loader: bus initiator for the span_cme register slave.
// Streams NUM_REGS parameter words to offsets 0..NUM_REGS-1, waits
// WAIT_CYCLES, reads RESULT_OFFSET and returns the result on a valid/ready port.
// Optional build macro LOADER_READBACK_EN adds a VERIFY pass that reads the
// parameter registers back and flags an XOR-checksum mismatch on check_err.
module span_cme_loader #(
    parameter int NUM_REGS      = 34,
    parameter int RESULT_OFFSET = 34,
    parameter int WAIT_CYCLES   = 8,
    parameter int READ_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [5:0]  offset,
    output logic [15:0] writeData,
    output logic        write,
    output logic        read,
    output logic        chipselect,
    input  logic [15:0] readData,
    output logic [15:0] result_data,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        check_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef LOADER_READBACK_EN
        S_VERIFY,
`endif
        S_WAIT,
        S_READ,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam logic [5:0] LAST_CNT  = 6'(NUM_REGS);
    localparam logic [5:0] RES_OFF   = 6'(RESULT_OFFSET);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
    localparam logic [1:0] LAT_LAST  = 2'(READ_LATENCY);
    // With no compute interval the result read follows the last bus cycle directly.
    localparam state_t AFTER_LOAD = (WAIT_CYCLES == 0) ? S_READ : S_WAIT;

    state_t      state_reg, state_next;
    logic [5:0]  count_reg, count_next;
    logic [7:0]  wait_reg, wait_next;
    logic [1:0]  lat_reg, lat_next;
    logic [5:0]  offset_reg, offset_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        write_reg, write_next;
    logic        read_reg, read_next;
    logic        cs_reg;
    logic        busy_reg;
    logic [15:0] result_reg, result_next;
    logic        rvalid_reg;
    logic        load_ready;

`ifdef LOADER_READBACK_EN
    logic [15:0] wsum_reg, wsum_next;
    logic [15:0] rsum_reg, rsum_next;
    logic        check_err_reg, check_err_next;
`endif

    assign load_ready   = (state_reg == S_LOAD) && (count_reg < LAST_CNT);
    assign in_ready     = load_ready;
    assign offset       = offset_reg;
    assign writeData    = wdata_reg;
    assign write        = write_reg;
    assign read         = read_reg;
    assign chipselect   = cs_reg;
    assign busy         = busy_reg;
    assign result_data  = result_reg;
    assign result_valid = rvalid_reg;

    // Next-state and next bus-cycle decode; bus outputs are registered from these.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        wait_next   = wait_reg;
        lat_next    = lat_reg;
        offset_next = offset_reg;
        wdata_next  = wdata_reg;
        write_next  = 1'b0;
        read_next   = 1'b0;
        result_next = result_reg;
`ifdef LOADER_READBACK_EN
        wsum_next      = wsum_reg;
        rsum_next      = rsum_reg;
        check_err_next = check_err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    count_next = 6'd0;
`ifdef LOADER_READBACK_EN
                    wsum_next      = 16'd0;
                    check_err_next = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid && load_ready) begin
                    write_next  = 1'b1;
                    offset_next = count_reg;
                    wdata_next  = in_data;
                    count_next  = count_reg + 6'd1;
`ifdef LOADER_READBACK_EN
                    wsum_next   = wsum_reg ^ in_data;
`endif
                end else if (count_reg == LAST_CNT) begin
                    // The final write is on the bus this cycle.
`ifdef LOADER_READBACK_EN
                    state_next  = S_VERIFY;
                    read_next   = 1'b1;
                    offset_next = 6'd0;
                    count_next  = 6'd0;
                    lat_next    = 2'd0;
                    rsum_next   = 16'd0;
`else
                    state_next  = AFTER_LOAD;
                    wait_next   = 8'd0;
`endif
                end
            end
`ifdef LOADER_READBACK_EN
            S_VERIFY: begin
                // count_reg is the offset whose readback is in flight.
                if (lat_reg == LAT_LAST) begin
                    rsum_next = rsum_reg ^ readData;
                    if (count_reg == LAST_CNT - 6'd1) begin
                        check_err_next = (wsum_reg != (rsum_reg ^ readData));
                        state_next     = AFTER_LOAD;
                        wait_next      = 8'd0;
                    end else begin
                        count_next  = count_reg + 6'd1;
                        read_next   = 1'b1;
                        offset_next = count_reg + 6'd1;
                        lat_next    = 2'd0;
                    end
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
`endif
            S_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    state_next = S_READ;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_READ: begin
                state_next = S_CAPTURE;
                lat_next   = 2'd1;
            end
            S_CAPTURE: begin
                if (lat_reg == LAT_LAST) begin
                    result_next = readData;
                    state_next  = S_HOLD;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            S_HOLD: begin
                if (rvalid_reg && result_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // The single result-read cycle is issued on entry to READ.
        if (state_next == S_READ) begin
            read_next   = 1'b1;
            offset_next = RES_OFF;
        end
    end

    // State, counters and registered bus/result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            count_reg  <= 6'd0;
            wait_reg   <= 8'd0;
            lat_reg    <= 2'd0;
            offset_reg <= 6'd0;
            wdata_reg  <= 16'd0;
            write_reg  <= 1'b0;
            read_reg   <= 1'b0;
            cs_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            result_reg <= 16'd0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            wait_reg   <= wait_next;
            lat_reg    <= lat_next;
            offset_reg <= offset_next;
            wdata_reg  <= wdata_next;
            write_reg  <= write_next;
            read_reg   <= read_next;
            cs_reg     <= write_next | read_next;
            busy_reg   <= (state_next != S_IDLE);
            result_reg <= result_next;
            rvalid_reg <= (state_next == S_HOLD);
        end
    end

`ifdef LOADER_READBACK_EN
    // Write/readback checksums and the sticky mismatch flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wsum_reg      <= 16'd0;
            rsum_reg      <= 16'd0;
            check_err_reg <= 1'b0;
        end else begin
            wsum_reg      <= wsum_next;
            rsum_reg      <= rsum_next;
            check_err_reg <= check_err_next;
        end
    end
    assign check_err = check_err_reg;
`else
    assign check_err = 1'b0;
`endif

endmodule
